// File: rtl/bram_window_reader_if.sv
// bram_window_reader_if: control and read-address bus between the window reader and its BRAM/DSP consumer.
// Rev 1.0
`default_nettype none

interface bram_window_reader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int K          = 3,
  parameter int POS_WIDTH  = 8
);
  logic                      i_start;
  logic                      i_stall;
  logic [ADDR_WIDTH*K*K-1:0] o_r_addrs;
  logic                      o_addr_valid;
  logic                      o_data_valid;
  logic [POS_WIDTH-1:0]      o_win_row;
  logic [POS_WIDTH-1:0]      o_win_col;
  logic                      o_last;
  logic                      o_busy;
  logic                      o_done;

  modport master (
    input  i_start, i_stall,
    output o_r_addrs, o_addr_valid, o_data_valid, o_win_row, o_win_col,
           o_last, o_busy, o_done
  );

  modport slave (
    output i_start, i_stall,
    input  o_r_addrs, o_addr_valid, o_data_valid, o_win_row, o_win_col,
           o_last, o_busy, o_done
  );
endinterface

`default_nettype wire

// File: rtl/bram_window_reader.sv
// bram_window_reader: sweeps a KxK stride-1 window over a row-major image, driving all K*K BRAM read ports per issue.
// Rev 1.0
`default_nettype none

module bram_window_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int IMG_W      = 7,
  parameter int IMG_H      = 3,
  parameter int K          = 3,
  parameter int POS_WIDTH  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  bram_window_reader_if.master bus
);
  localparam int                   RAM_PORTS = K * K;
  localparam logic [POS_WIDTH-1:0] LAST_ROW  = POS_WIDTH'(IMG_H - K);
  localparam logic [POS_WIDTH-1:0] LAST_COL  = POS_WIDTH'(IMG_W - K);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [POS_WIDTH-1:0]            r_row;
  logic [POS_WIDTH-1:0]            r_col;
  logic [POS_WIDTH-1:0]            w_nxt_row;
  logic [POS_WIDTH-1:0]            w_nxt_col;
  logic [ADDR_WIDTH*RAM_PORTS-1:0] r_addrs;
  logic [ADDR_WIDTH*RAM_PORTS-1:0] w_addrs;
  logic                            r_addr_valid;
  logic                            r_data_valid;
  logic                            r_last;
  logic [POS_WIDTH-1:0]            r_win_row;
  logic [POS_WIDTH-1:0]            r_win_col;
  logic                            w_launch;
  logic                            w_issue;
  logic                            w_is_last;

  // Next window position: (0,0) on launch, otherwise the raster successor.
  always_comb begin
    w_launch  = (r_state == S_IDLE) && bus.i_start;
    w_issue   = (r_state == S_RUN) && !bus.i_stall;
    w_is_last = (r_row == LAST_ROW) && (r_col == LAST_COL);
    w_nxt_row = r_row;
    w_nxt_col = r_col;
    if (w_launch) begin
      w_nxt_row = '0;
      w_nxt_col = '0;
    end else if (r_col == LAST_COL) begin
      w_nxt_row = r_row + POS_WIDTH'(1);
      w_nxt_col = '0;
    end else begin
      w_nxt_col = r_col + POS_WIDTH'(1);
    end
  end

  always_comb begin
    w_addrs = '0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        w_addrs[ADDR_WIDTH*(kr*K+kc) +: ADDR_WIDTH] =
          ADDR_WIDTH'((int'(w_nxt_row) + kr) * IMG_W + int'(w_nxt_col) + kc);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next_state = S_RUN;
      S_RUN:   if (w_issue && w_is_last) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_addrs      <= '0;
      r_addr_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_last       <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_data_valid <= w_issue;
      r_last       <= w_issue && w_is_last;
      if (w_issue) begin
        r_win_row <= r_row;
        r_win_col <= r_col;
      end
      if (w_launch) begin
        r_addr_valid <= 1'b1;
      end else if (w_issue && w_is_last) begin
        r_addr_valid <= 1'b0;
      end
      // The final issue leaves the counters and addresses on the last window.
      if (w_launch || (w_issue && !w_is_last)) begin
        r_row   <= w_nxt_row;
        r_col   <= w_nxt_col;
        r_addrs <= w_addrs;
      end
    end
  end

  assign bus.o_r_addrs    = r_addrs;
  assign bus.o_addr_valid = r_addr_valid;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_win_row    = r_win_row;
  assign bus.o_win_col    = r_win_col;
  assign bus.o_last       = r_last;
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_done       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bram_window_reader.sv
// tb_bram_window_reader: three reader instances (7x3, 5x5, 3x3) checked against a window-index reference model.
// Rev 1.0
`default_nettype none

module tb_bram_window_reader;
  localparam int AW = 6;
  localparam int KK = 3;
  localparam int PW = 8;
  localparam int NP = KK * KK;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int W [ND] = '{7, 5, 3};
  int H [ND] = '{3, 5, 3};

  logic          start [ND];
  logic          stall [ND];
  logic          av    [ND];
  logic          dv    [ND];
  logic          lst   [ND];
  logic          busy  [ND];
  logic          done  [ND];
  logic [PW-1:0] wrow  [ND];
  logic [PW-1:0] wcol  [ND];
  logic [AW*NP-1:0] addrs [ND];
  logic [AW*NP-1:0] rd    [ND];
  logic [AW-1:0]    mem   [64];

  bram_window_reader_if #(.ADDR_WIDTH(AW), .K(KK), .POS_WIDTH(PW)) if0 ();
  bram_window_reader_if #(.ADDR_WIDTH(AW), .K(KK), .POS_WIDTH(PW)) if1 ();
  bram_window_reader_if #(.ADDR_WIDTH(AW), .K(KK), .POS_WIDTH(PW)) if2 ();

  bram_window_reader #(.ADDR_WIDTH(AW), .IMG_W(7), .IMG_H(3), .K(KK), .POS_WIDTH(PW))
    u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0.master));
  bram_window_reader #(.ADDR_WIDTH(AW), .IMG_W(5), .IMG_H(5), .K(KK), .POS_WIDTH(PW))
    u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1.master));
  bram_window_reader #(.ADDR_WIDTH(AW), .IMG_W(3), .IMG_H(3), .K(KK), .POS_WIDTH(PW))
    u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2.master));

  assign if0.i_start = start[0];
  assign if0.i_stall = stall[0];
  assign av[0] = if0.o_addr_valid;  assign dv[0] = if0.o_data_valid;
  assign lst[0] = if0.o_last;       assign busy[0] = if0.o_busy;
  assign done[0] = if0.o_done;      assign addrs[0] = if0.o_r_addrs;
  assign wrow[0] = if0.o_win_row;   assign wcol[0] = if0.o_win_col;

  assign if1.i_start = start[1];
  assign if1.i_stall = stall[1];
  assign av[1] = if1.o_addr_valid;  assign dv[1] = if1.o_data_valid;
  assign lst[1] = if1.o_last;       assign busy[1] = if1.o_busy;
  assign done[1] = if1.o_done;      assign addrs[1] = if1.o_r_addrs;
  assign wrow[1] = if1.o_win_row;   assign wcol[1] = if1.o_win_col;

  assign if2.i_start = start[2];
  assign if2.i_stall = stall[2];
  assign av[2] = if2.o_addr_valid;  assign dv[2] = if2.o_data_valid;
  assign lst[2] = if2.o_last;       assign busy[2] = if2.o_busy;
  assign done[2] = if2.o_done;      assign addrs[2] = if2.o_r_addrs;
  assign wrow[2] = if2.o_win_row;   assign wcol[2] = if2.o_win_col;

  // Registered-read BRAM per reader, contents mem[a] = a.
  always_ff @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NP; p++) begin
        rd[d][p*AW +: AW] <= mem[addrs[d][p*AW +: AW]];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state, per reader.
  bit active    [ND];
  bit av_prev   [ND];
  bit last_prev [ND];
  bit done_prev [ND];
  int rx        [ND];
  int dvcnt     [ND];
  bit pre_start [ND];
  bit pre_stall [ND];

  task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL d%0d_%s observed=%0h expected=%0h", d, tag, obs, exp);
    end
  endtask

  function automatic logic [AW*NP-1:0] win_addrs(input int w, input int r, input int c);
    logic [AW*NP-1:0] v;
    v = '0;
    for (int kr = 0; kr < KK; kr++)
      for (int kc = 0; kc < KK; kc++)
        v[(kr*KK+kc)*AW +: AW] = AW'((r + kr) * w + c + kc);
    return v;
  endfunction

  task automatic check_dut(input int i);
    int nwc, total, r, c;
    bit issued, lastw, exp_done, exp_av;
    nwc   = W[i] - KK + 1;
    total = nwc * (H[i] - KK + 1);
    if (pre_start[i] && !active[i]) begin
      active[i] = 1'b1;
      rx[i]     = 0;
      dvcnt[i]  = 0;
    end else if (done_prev[i]) begin
      active[i] = 1'b0;
    end
    issued = av_prev[i] && !pre_stall[i];
    lastw  = 1'b0;
    if (dv[i] === 1'b1) dvcnt[i]++;
    chk(i, "data_valid", 64'(dv[i]), 64'(issued));
    if (issued) begin
      r     = rx[i] / nwc;
      c     = rx[i] % nwc;
      lastw = (rx[i] == total - 1);
      chk(i, "win_row", 64'(wrow[i]), 64'(r));
      chk(i, "win_col", 64'(wcol[i]), 64'(c));
      chk(i, "bram_word", 64'(rd[i]), 64'(win_addrs(W[i], r, c)));
      rx[i]++;
    end
    chk(i, "last", 64'(lst[i]), 64'(lastw));
    exp_done = last_prev[i];
    chk(i, "done", 64'(done[i]), 64'(exp_done));
    if (exp_done) chk(i, "windows_per_sweep", 64'(dvcnt[i]), 64'(total));
    chk(i, "busy", 64'(busy[i]), 64'(active[i]));
    exp_av = active[i] && (rx[i] < total);
    chk(i, "addr_valid", 64'(av[i]), 64'(exp_av));
    if (exp_av)
      chk(i, "r_addrs", 64'(addrs[i]), 64'(win_addrs(W[i], rx[i] / nwc, rx[i] % nwc)));
    done_prev[i] = exp_done;
    last_prev[i] = lastw;
    av_prev[i]   = exp_av;
  endtask

  task automatic tick();
    for (int i = 0; i < ND; i++) begin
      pre_start[i] = start[i];
      pre_stall[i] = stall[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0;
      check_dut(i);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      active[i] = 0; av_prev[i] = 0; last_prev[i] = 0; done_prev[i] = 0;
      rx[i] = 0; dvcnt[i] = 0;
    end
  endtask

  task automatic check_zero();
    for (int i = 0; i < ND; i++) begin
      chk(i, "rst_addr_valid", 64'(av[i]), 64'd0);
      chk(i, "rst_data_valid", 64'(dv[i]), 64'd0);
      chk(i, "rst_last", 64'(lst[i]), 64'd0);
      chk(i, "rst_busy", 64'(busy[i]), 64'd0);
      chk(i, "rst_done", 64'(done[i]), 64'd0);
      chk(i, "rst_row", 64'(wrow[i]), 64'd0);
      chk(i, "rst_col", 64'(wcol[i]), 64'd0);
      chk(i, "rst_addrs", 64'(addrs[i]), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < ND; i++) begin
      if (KK > W[i] || KK > H[i] || (1 << AW) < W[i] * H[i]) begin
        $display("FAIL param_constraints instance=%0d", i);
        $fatal(1, "bad parameters");
      end
      start[i] = 1'b0;
      stall[i] = 1'b0;
    end
    for (int a = 0; a < 64; a++) mem[a] = AW'(a);
    model_reset();

    // Reset state.
    tick();
    tick();
    check_zero();
    rst_n = 1'b1;
    tick();

    // Plain sweep on all three images.
    for (int i = 0; i < ND; i++) start[i] = 1'b1;
    repeat (15) tick();

    // Three-cycle stall while window (0,1) is presented.
    start[0] = 1'b1;
    tick();
    tick();
    stall[0] = 1'b1;
    repeat (3) tick();
    stall[0] = 1'b0;
    repeat (8) tick();

    // Start held through the whole sweep including DONE, then a fresh sweep.
    for (int n = 0; n < 8; n++) begin
      start[0] = 1'b1;
      start[1] = 1'b1;
      tick();
    end
    repeat (12) tick();
    start[0] = 1'b1;
    repeat (10) tick();

    // Asynchronous reset while window (0,3) is presented.
    start[0] = 1'b1;
    tick();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_zero();
    model_reset();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    start[0] = 1'b1;
    repeat (10) tick();

    // Random stalls and start pulses.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < ND; i++) begin
        stall[i] = ($urandom_range(0, 2) == 0);
        start[i] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end
    for (int i = 0; i < ND; i++) stall[i] = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_window_reader.md
Name: bram_window_reader

Overview:
- Read-side controller for the multi-port convolution line BRAM.
- Sweeps a KxK window with stride 1 across an IMG_W x IMG_H image. The image is stored row-major, so address = row*IMG_W + col.
- Each issue cycle drives all K*K read addresses in parallel.
- Tracks the BRAM's 1-cycle registered read latency and flags when the BRAM output word is a valid window for the downstream DSP cascade.

Parameters:
- ADDR_WIDTH, 6, width of one read address; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H.
- IMG_W, 7, image width in pixels.
- IMG_H, 3, image height in pixels.
- K, 3, kernel side; RAM_PORTS = K*K is a localparam. Requires K <= IMG_W and K <= IMG_H.
- POS_WIDTH, 8, width of the window row/col position outputs.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; starts one full image sweep when idle.
- i_stall  in  1  downstream backpressure; holds the current window while high.
- o_r_addrs  out  ADDR_WIDTH*K*K  packed read addresses; port p occupies bits [ADDR_WIDTH*p +: ADDR_WIDTH]; connects to the BRAM read-address bus.
- o_addr_valid  out  1  o_r_addrs holds a window to be issued.
- o_data_valid  out  1  the BRAM data word this cycle is a fresh, valid window.
- o_win_row  out  POS_WIDTH  window top-left row, aligned with o_data_valid.
- o_win_col  out  POS_WIDTH  window top-left col, aligned with o_data_valid.
- o_last  out  1  high with o_data_valid for the final window.
- o_busy  out  1  sweep in progress.
- o_done  out  1  single-cycle pulse when the sweep completes.

Behaviour:
- Reset: async on i_rst_n=0. State=IDLE; all outputs, counters and pipeline registers = 0. Reset asserted mid-sweep aborts the sweep immediately, with no o_done. After release the block waits in IDLE for a new i_start.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN: on i_start=1. Row/col counters r=c=0. On the next cycle o_busy=1, o_addr_valid=1 and o_r_addrs = window (0,0).
- Address map: port p = kr*K + kc (kr, kc in 0..K-1); address = (r+kr)*IMG_W + (c+kc). All addresses are registered outputs.
- Issue: occurs in any RUN cycle with i_stall=0. On an issue:
  - if c < IMG_W-K, then c++;
  - else c=0, r++.
- Stall: i_stall=1 in RUN holds the counters and o_r_addrs unchanged; o_addr_valid stays 1.
- Last window: issuing window (IMG_H-K, IMG_W-K) moves RUN -> DRAIN and drops o_addr_valid to 0.
- Latency: o_data_valid(t+1) = o_addr_valid(t) & ~i_stall(t).
  - o_win_row, o_win_col and o_last are delayed by the same 1-cycle pipeline.
  - o_last(t+1) = 1 only for the issue of the last window.
  - Repeated reads during a stall never produce duplicate o_data_valid.
- DRAIN: carries the final o_data_valid/o_last cycle; goes to DONE unconditionally.
- DONE: o_done=1 for one cycle, o_busy=1 in this cycle; next state IDLE with o_busy=0.
- Windows per sweep: (IMG_W-K+1)*(IMG_H-K+1), exactly one o_data_valid each, in raster order.
- i_start while not IDLE is ignored.
- i_stall while in IDLE, DRAIN or DONE has no effect.
- Outside RUN, o_r_addrs holds its last value; o_r_addrs is "don't care" when o_addr_valid=0.
- Degenerate image K=IMG_W=IMG_H: exactly one window; RUN lasts one issue cycle.
- No arithmetic overflow when parameter constraints hold; the bench checks the constraints at elaboration.

Test Plan:
- Default params, i_start pulse, no stall:
  - o_addr_valid high 5 cycles starting 1 cycle after start;
  - window (0,0) addresses ports 0..8 = 0,1,2,7,8,9,14,15,16;
  - window (0,4) = 4,5,6,11,12,13,18,19,20;
  - o_data_valid 5 pulses lagging by 1 cycle, o_win_col 0..4, o_last on the 5th;
  - o_done one cycle after o_last.
- IMG_W=5, IMG_H=5:
  - 9 windows in raster order;
  - after (0,2) the next window is (1,0) with port0=5, port8=17;
  - final window (2,2) has port0=12, port8=24 and o_last=1.
- Stall: hold i_stall=1 for 3 cycles on window (0,1):
  - o_r_addrs is frozen and o_data_valid=0 during the stall;
  - window (0,1) reported exactly once;
  - total o_data_valid pulses = 5.
- i_start pulsed again mid-sweep and during DONE:
  - ignored, sweep order unchanged, single o_done;
  - a new i_start after return to IDLE repeats the sequence identically.
- i_rst_n=0 asynchronously while on window (0,3):
  - all outputs 0 immediately, no o_done;
  - after release and i_start, the sweep restarts at (0,0).
- Scoreboard with a live BRAM instance preloaded with mem[a]=a:
  - every o_data_valid word equals the expected 9 addresses of (o_win_row, o_win_col).
